// File: rtl/hazard_if.sv
// Hazard controller port bundle: ID-stage instruction fields in, stall/bubble,
// registered forward selects, stall counter and scoreboard debug view out.
interface hazard_if #(
  parameter int GRP_ADDR_WIDTH  = 4,
  parameter int STALL_CNT_WIDTH = 16
);
  // Handshake: id_valid qualifies every id_* field. stall acts as "not ready":
  // the ID instruction moves into EX on a rising edge only when
  // id_valid & ~stall & ~flush, otherwise EX receives a bubble.
  logic                       id_valid;
  logic [GRP_ADDR_WIDTH-1:0]  id_rs;
  logic [GRP_ADDR_WIDTH-1:0]  id_rt;
  logic                       id_rs_used;
  logic                       id_rt_used;
  logic                       id_reg_we;
  logic [GRP_ADDR_WIDTH-1:0]  id_dest;
  logic                       id_is_load;
  logic                       id_fl_we;
  logic                       id_fl_read;
  logic                       flush;
  logic                       stall;
  logic                       bubble;
  logic [1:0]                 fwd_a_sel;
  logic [1:0]                 fwd_b_sel;
  logic [STALL_CNT_WIDTH-1:0] stall_count;
  logic [3*(GRP_ADDR_WIDTH+4)-1:0] sb_dbg;

  modport master (
    output id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_reg_we,
           id_dest, id_is_load, id_fl_we, id_fl_read, flush,
    input  stall, bubble, fwd_a_sel, fwd_b_sel, stall_count, sb_dbg
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_rs_used, id_rt_used, id_reg_we,
           id_dest, id_is_load, id_fl_we, id_fl_read, flush,
    output stall, bubble, fwd_a_sel, fwd_b_sel, stall_count, sb_dbg
  );
endinterface

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: EX/MEM/WB destination scoreboard, registered
// operand-forward selects, load-use stall. LAPIDO_FLAG_HAZARD_EN adds a flag-use stall.
module hazard_ctrl #(
  parameter int GRP_ADDR_WIDTH  = 4,
  parameter int STALL_CNT_WIDTH = 16
) (
  input  logic     clk,
  input  logic     rst,
  hazard_if.slave  hz
);

  typedef struct packed {
    logic                      valid;
    logic                      we;
    logic [GRP_ADDR_WIDTH-1:0] dest;
    logic                      is_load;
    logic                      fl_we;
  } sb_entry_t;

  sb_entry_t ex_q, ex_d, mem_q, wb_q;
  logic [1:0] fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [STALL_CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic load_use, flag_use, stall, xfer;

  // Youngest producer first: EX entry becomes MEM (01), MEM entry becomes WB (10).
  function automatic logic [1:0] fwd_sel(input logic used,
                                         input logic [GRP_ADDR_WIDTH-1:0] src,
                                         input sb_entry_t ex_e,
                                         input sb_entry_t mem_e);
    if (used && ex_e.valid && ex_e.we && src == ex_e.dest)
      return 2'b01;
    else if (used && mem_e.valid && mem_e.we && src == mem_e.dest)
      return 2'b10;
    else
      return 2'b00;
  endfunction

  assign load_use = hz.id_valid & ex_q.valid & ex_q.we & ex_q.is_load &
                    ((hz.id_rs_used & (hz.id_rs == ex_q.dest)) |
                     (hz.id_rt_used & (hz.id_rt == ex_q.dest)));

`ifdef LAPIDO_FLAG_HAZARD_EN
  assign flag_use = hz.id_valid & hz.id_fl_read & ex_q.valid & ex_q.fl_we;
`else
  logic unused_fl_read;
  assign flag_use       = 1'b0;
  assign unused_fl_read = hz.id_fl_read;
`endif

  assign stall = load_use | flag_use;
  assign xfer  = hz.id_valid & ~stall & ~hz.flush;

  always_comb begin
    ex_d    = '0;
    fwd_a_d = 2'b00;
    fwd_b_d = 2'b00;
    cnt_d   = cnt_q;
    if (xfer) begin
      ex_d.valid   = 1'b1;
      ex_d.we      = hz.id_reg_we;
      ex_d.dest    = hz.id_dest;
      ex_d.is_load = hz.id_is_load;
      ex_d.fl_we   = hz.id_fl_we;
      fwd_a_d      = fwd_sel(hz.id_rs_used, hz.id_rs, ex_q, mem_q);
      fwd_b_d      = fwd_sel(hz.id_rt_used, hz.id_rt, ex_q, mem_q);
    end
    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= 2'b00;
      fwd_b_q <= 2'b00;
      cnt_q   <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= ex_q;
      wb_q    <= mem_q;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign hz.stall       = stall;
  assign hz.bubble      = stall | hz.flush;
  assign hz.fwd_a_sel   = fwd_a_q;
  assign hz.fwd_b_sel   = fwd_b_q;
  assign hz.stall_count = cnt_q;
  assign hz.sb_dbg      = {ex_q, mem_q, wb_q};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed table-driven bench for hazard_ctrl; narrow stall counter so the
// saturation corner is reachable in a few dozen cycles.
module tb_hazard_ctrl;

`ifdef LAPIDO_FLAG_HAZARD_EN
  localparam int FL = 1;
`else
  localparam int FL = 0;
`endif

  logic clk;
  logic rst;

  hazard_if #(.GRP_ADDR_WIDTH(4), .STALL_CNT_WIDTH(3)) hz ();

  hazard_ctrl #(.GRP_ADDR_WIDTH(4), .STALL_CNT_WIDTH(3)) u_dut (
    .clk (clk),
    .rst (rst),
    .hz  (hz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [3:0] rs;
    logic       rsu;
    logic [3:0] rt;
    logic       rtu;
    logic       we;
    logic [3:0] dest;
    logic       ld;
    logic       flwe;
    logic       flrd;
    logic       fl;
    logic       es;
    logic       eb;
    logic [1:0] ea;
    logic [1:0] eb2;
    int         ec;
  } vec_t;

  vec_t tbl[$];
  int   errors = 0;
  int   checks = 0;

  function automatic vec_t mk(logic v, logic [3:0] rs, logic rsu, logic [3:0] rt,
                              logic rtu, logic we, logic [3:0] dest, logic ld,
                              logic flwe, logic flrd, logic fl, logic es, logic eb,
                              logic [1:0] ea, logic [1:0] eb2, int ec);
    vec_t r;
    r.v = v; r.rs = rs; r.rsu = rsu; r.rt = rt; r.rtu = rtu; r.we = we;
    r.dest = dest; r.ld = ld; r.flwe = flwe; r.flrd = flrd; r.fl = fl;
    r.es = es; r.eb = eb; r.ea = ea; r.eb2 = eb2; r.ec = ec;
    return r;
  endfunction

  task automatic drive(input vec_t r);
    hz.id_valid   = r.v;
    hz.id_rs      = r.rs;
    hz.id_rs_used = r.rsu;
    hz.id_rt      = r.rt;
    hz.id_rt_used = r.rtu;
    hz.id_reg_we  = r.we;
    hz.id_dest    = r.dest;
    hz.id_is_load = r.ld;
    hz.id_fl_we   = r.flwe;
    hz.id_fl_read = r.flrd;
    hz.flush      = r.fl;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  vec_t nop_v, lw_r2, use_r2;

  initial begin
    nop_v  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    lw_r2  = mk(1, 1, 1, 0, 0, 1, 2, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    use_r2 = mk(1, 2, 1, 2, 1, 1, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // v rs rsu rt rtu we dest ld flwe flrd flush | stall bubble fwd_a fwd_b count
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));      // 0 idle
    tbl.push_back(mk(1,1,1,2,1,1,3,0,0,0,0, 0,0,0,0,0));      // 1 ADD r3
    tbl.push_back(mk(1,3,1,5,1,1,4,0,0,0,0, 0,0,0,0,0));      // 2 SUB r4<-r3,r5
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,1,0,0));      // 3 SUB in EX: 01/00
    tbl.push_back(mk(1,1,1,2,1,1,3,0,0,0,0, 0,0,0,0,0));      // 4 ADD r3
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));      // 5 NOP
    tbl.push_back(mk(1,1,1,3,1,1,6,0,0,0,0, 0,0,0,0,0));      // 6 OR r6<-r1,r3
    tbl.push_back(mk(1,1,1,2,1,1,3,0,0,0,0, 0,0,0,2,0));      // 7 OR in EX: 00/10
    tbl.push_back(mk(1,1,1,2,1,1,3,0,0,0,0, 0,0,0,0,0));      // 8 ADD r3 again
    tbl.push_back(mk(1,1,1,3,1,1,6,0,0,0,0, 0,0,0,0,0));      // 9 OR r6<-r1,r3
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,1,0));      // 10 youngest wins: 01
    tbl.push_back(mk(1,1,1,0,0,1,2,1,0,0,0, 0,0,0,0,0));      // 11 LW r2
    tbl.push_back(mk(1,2,1,2,1,1,7,0,0,0,0, 1,1,0,0,0));      // 12 ADD r7<-r2,r2 stalls
    tbl.push_back(mk(1,2,1,2,1,1,7,0,0,0,0, 0,0,0,0,1));      // 13 held ADD proceeds
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,2,2,1));      // 14 ADD in EX: 10/10
    tbl.push_back(mk(1,1,1,0,0,1,2,1,0,0,0, 0,0,0,0,1));      // 15 LW r2
    tbl.push_back(mk(1,2,1,2,1,1,7,0,0,0,1, 1,1,0,0,1));      // 16 user with flush
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,2));      // 17 bubbled, fwd 00
    tbl.push_back(mk(1,2,1,2,1,1,7,0,0,0,0, 0,0,0,0,2));      // 18 LW now in WB only
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,2));      // 19 WB not forwarded
    tbl.push_back(mk(1,1,1,2,1,0,0,0,1,0,0, 0,0,0,0,2));      // 20 CMP (fl_we)
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1,0, FL,FL,0,0,2));    // 21 BEQ (fl_read)
    tbl.push_back(mk(1,0,0,0,0,0,0,0,0,1,0, 0,0,0,0,2+FL));   // 22 BEQ again
    tbl.push_back(mk(1,1,1,2,1,1,9,0,0,0,1, 0,1,0,0,2+FL));   // 23 flush only
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,2+FL));   // 24 flushed: 00
    tbl.push_back(mk(1,1,1,2,1,1,3,0,0,0,0, 0,0,0,0,2+FL));   // 25 ADD r3
    tbl.push_back(mk(1,3,0,3,1,1,10,0,0,0,0, 0,0,0,0,2+FL));  // 26 rs unused, rt used
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,0,1,2+FL));   // 27 00/01
    tbl.push_back(mk(1,1,1,0,0,1,5,1,0,0,0, 0,0,0,0,2+FL));   // 28 LW r5
    tbl.push_back(mk(1,1,1,0,0,1,5,1,0,0,0, 0,0,0,0,2+FL));   // 29 LW r5 again
    tbl.push_back(mk(1,5,1,6,1,1,8,0,0,0,0, 1,1,0,0,2+FL));   // 30 ADD r8<-r5,r6 stalls
    tbl.push_back(mk(1,5,1,6,1,1,8,0,0,0,0, 0,0,0,0,3+FL));   // 31 single stall only
    tbl.push_back(mk(0,0,0,0,0,0,0,0,0,0,0, 0,0,2,0,3+FL));   // 32 10/00

    rst = 1'b1;
    drive(nop_v);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("reset stall", 32'(hz.stall), 0);
    check("reset bubble", 32'(hz.bubble), 0);
    check("reset fwd_a", 32'(hz.fwd_a_sel), 0);
    check("reset fwd_b", 32'(hz.fwd_b_sel), 0);
    check("reset count", 32'(hz.stall_count), 0);
    check("reset scoreboard", 32'(hz.sb_dbg), 0);

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      drive(tbl[i]);
      #1;
      check($sformatf("row%0d stall", i), 32'(hz.stall), 32'(tbl[i].es));
      check($sformatf("row%0d bubble", i), 32'(hz.bubble), 32'(tbl[i].eb));
      check($sformatf("row%0d fwd_a", i), 32'(hz.fwd_a_sel), 32'(tbl[i].ea));
      check($sformatf("row%0d fwd_b", i), 32'(hz.fwd_b_sel), 32'(tbl[i].eb2));
      check($sformatf("row%0d count", i), 32'(hz.stall_count), 32'(tbl[i].ec));
    end

    // Eight more load-use stalls push the 3-bit counter past its ceiling.
    for (int k = 0; k < 8; k++) begin
      @(negedge clk); drive(lw_r2);
      @(negedge clk); drive(use_r2); #1;
      check($sformatf("sat loop%0d stall", k), 32'(hz.stall), 1);
      @(negedge clk); drive(use_r2);
    end
    @(negedge clk); drive(nop_v); #1;
    check("saturated count", 32'(hz.stall_count), 7);
    @(negedge clk); #1;
    check("saturated count hold", 32'(hz.stall_count), 7);

    // Reset landing in the middle of a load-use stall.
    @(negedge clk); drive(lw_r2);
    @(negedge clk); drive(use_r2); #1;
    check("pre-reset stall", 32'(hz.stall), 1);
    rst = 1'b1;
    @(negedge clk); #1;
    check("reset mid-stall stall", 32'(hz.stall), 0);
    check("reset mid-stall bubble", 32'(hz.bubble), 0);
    check("reset mid-stall count", 32'(hz.stall_count), 0);
    check("reset mid-stall fwd_a", 32'(hz.fwd_a_sel), 0);
    rst = 1'b0;
    drive(nop_v);
    @(negedge clk); #1;
    check("post-reset stall", 32'(hz.stall), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
# hazard_ctrl

Pipeline hazard controller for the core_lapido integer pipeline. It tracks the destination registers of instructions in flight in the EX, MEM and WB stages. From that scoreboard it produces registered operand-forwarding selects for the EX stage ALU operand muxes, and a combinational stall/bubble for load-use (and optionally flag-use) hazards. It sits beside the ID/EX pipeline register and drives the PC/IF-ID hold and the ID/EX control clear.

## Interface
- `STALL_CNT_WIDTH`, default 16: width of the saturating stall-event counter.

- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `id_valid`  in  1  a real instruction is in ID this cycle.
- `id_rs`, `id_rt`  in  `GRP_ADDR_WIDTH` each  source register addresses of the ID instruction.
- `id_rs_used`, `id_rt_used`  in  1 each  the corresponding source is actually read.
- `id_reg_we`  in  1  the ID instruction writes a GPR.
- `id_dest`  in  `GRP_ADDR_WIDTH`  resolved destination (rt, rd or 15, already muxed upstream).
- `id_is_load`  in  1  the ID instruction is a memory load.
- `id_fl_we`  in  1  the ID instruction writes the ALU flags.
- `id_fl_read`  in  1  the ID instruction reads the flags (conditional branch).
- `flush`  in  1  kill the ID instruction (branch taken in EX).
- `stall`  out  1  hold PC and IF/ID this cycle (combinational).
- `bubble`  out  1  clear ID/EX control signals (combinational, `stall | flush`).
- `fwd_a_sel`, `fwd_b_sel`  out  2 each  EX operand mux select, registered: 00 register file, 01 MEM-stage ALU result, 10 WB-stage write data, 11 never driven.
- `stall_count`  out  `STALL_CNT_WIDTH`  saturating count of stall cycles.

## Operation
- Scoreboard: three entries, EX, MEM and WB. Each entry holds `valid`, `we`, `dest`, `is_load`, `fl_we`.
- Every cycle: WB ← MEM and MEM ← EX. EX ← ID fields if `id_valid & ~stall & ~flush`; otherwise EX ← bubble (all fields 0).
- Load-use hazard: `stall` = `id_valid` & EX.valid & EX.we & EX.is_load & ((`id_rs_used` & `id_rs`==EX.dest) | (`id_rt_used` & `id_rt`==EX.dest)).
- The stall lasts exactly one cycle. Next cycle the load is in MEM, and the dependent instruction then gets forwarding from WB (10).
- Forward select, computed at ID→EX transfer for each of rs→`fwd_a_sel` and rt→`fwd_b_sel`:
  - if used & EX.valid & EX.we & src==EX.dest → 01;
  - else if used & MEM.valid & MEM.we & src==MEM.dest → 10;
  - else 00.
  - The EX entry becomes MEM and the MEM entry becomes WB as the instruction enters EX, so these selects are correct in the EX cycle.
- Priority: the youngest producer wins. If both entries match, the result is 01.
- All 16 registers are architectural; there is no zero-register special case. Writes from the entry leaving WB are not forwarded: the register file is write-before-read.
- When ID→EX is blocked (`stall`, `flush` or `~id_valid`), both fwd registers load 00.
- `flush` has priority over `stall` for the EX entry. `stall` is still reported when `flush` is high (PC redirect overrides upstream).
- `stall_count` increments on each cycle with `stall`=1 and saturates at all-ones (no wrap).

## Timing
- Reset: all scoreboard entries 0, `fwd_a_sel`=`fwd_b_sel`=00, `stall_count`=0. Hence `stall`=0 and `bubble`=`flush`.
- `stall` and `bubble` are combinational from the registered scoreboard and ID inputs, valid in the same cycle.
- Forward selects are registered: latency 1 cycle from ID inputs.
- Reset asserted mid-stall clears the scoreboard at the next edge; `stall` drops the same cycle `rst` takes effect.
- Back-to-back loads to the same dest with a dependent third instruction: a single 1-cycle stall, keyed on the youngest load.

## Configuration
- `LAPIDO_FLAG_HAZARD_EN` defined: `stall` also asserts when `id_valid & id_fl_read & EX.valid & EX.fl_we`. This is a one-cycle stall until the flag writer has left EX. It is OR-ed with the load-use term and counted in `stall_count`.
- Not defined: the flag term is absent, `id_fl_read`/`fl_we` are ignored, and flag ordering is the compiler's responsibility.

## Test plan
- Reset for 2 cycles, then idle → `stall`=0, `fwd_*`=00, `stall_count`=0.
- ADD r3 then SUB r4←r3,r5 → SUB in EX with `fwd_a_sel`=01, `fwd_b_sel`=00, no stall.
- ADD r3; NOP; OR r6←r1,r3 → OR in EX with `fwd_b_sel`=10. The same with ADD r3; ADD r3 back-to-back feeding OR → 01 (youngest wins).
- LW r2; ADD r7←r2,r2 → `stall`=1 for exactly one cycle, `bubble`=1, then ADD in EX with both selects 10; `stall_count`=1.
- LW r2 with `flush`=1 the same cycle ADD r2-user is in ID → EX entry bubbled, fwd 00, no further stall.
- With `LAPIDO_FLAG_HAZARD_EN`: CMP (`fl_we`) then BEQ (`fl_read`) → 1-cycle stall. Without it → no stall.
